fetch_controller: RTL and testbench

//  Sequences the combinational Instruction_Memory: owns the program counter and

---
 rtl/fetch_controller.sv | 125 ++++++++++++
 tb/tb_fetch_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the pc, drives the combinational instruction memory and
// feeds decode through a 2-entry prefetch buffer with a valid/ready handshake.
module fetch_controller #(
    parameter int                PC_W       = 8,
    parameter int                INSTR_W    = 8,
    parameter logic [PC_W-1:0]   RESET_PC   = 8'h00,
    parameter logic [INSTR_W-1:0] HALT_INSTR = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    mem_pc,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    e0_pc;
    logic [PC_W-1:0]    e1_pc;
    logic [INSTR_W-1:0] e0_instr;
    logic [INSTR_W-1:0] e1_instr;
    logic [1:0]         cnt;

    logic pop;
    logic push;
    logic is_halt;

    assign mem_pc    = pc;
    assign out_valid = (cnt != 2'd0);
    assign out_pc    = e0_pc;
    assign out_instr = e0_instr;
    assign pop       = out_valid && out_ready;
    assign is_halt   = (mem_instr == HALT_INSTR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = RUN;
        end else begin
            unique case (state)
                IDLE:    if (start) state_nxt = RUN;
                RUN:     if (push && is_halt) state_nxt = HALTED;
                default: state_nxt = state;
            endcase
        end
    end

    // A pop frees a slot in the same cycle, so a full buffer can still accept.
    always_comb begin
        halted = (state == HALTED);
        push   = (state == RUN) && !redirect_valid && ((cnt != 2'd2) || pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            cnt      <= 2'd0;
            e0_pc    <= '0;
            e1_pc    <= '0;
            e0_instr <= '0;
            e1_instr <= '0;
        end else if (redirect_valid) begin
            pc  <= redirect_pc;
            cnt <= 2'd0;
        end else begin
            if (push && !is_halt) begin
                pc <= pc + PC_W'(1);
            end
            unique case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        e0_pc    <= pc;
                        e0_instr <= mem_instr;
                    end else begin
                        e1_pc    <= pc;
                        e1_instr <= mem_instr;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0_pc    <= e1_pc;
                    e0_instr <= e1_instr;
                    cnt      <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        e0_pc    <= e1_pc;
                        e0_instr <= e1_instr;
                        e1_pc    <= pc;
                        e1_instr <= mem_instr;
                    end else begin
                        e0_pc    <= pc;
                        e0_instr <= mem_instr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       redirect_valid;
    logic [7:0] redirect_pc;
    logic [7:0] mem_pc;
    logic [7:0] mem_instr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pc;
    logic [7:0] out_instr;
    logic       halted;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 run, 2 halted; queue holds {pc, instr}.
    int          m_state;
    logic [7:0]  m_pc;
    logic [15:0] m_q[$];

    assign mem_instr = mem[mem_pc];

    always #5 clk = ~clk;

    fetch_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_pc         (mem_pc),
        .mem_instr      (mem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted)
    );

    task automatic tick();
        logic [15:0] e;
        if (!rst_n) begin
            m_q.delete();
            m_pc    = 8'h00;
            m_state = 0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_pc    = redirect_pc;
            m_state = 1;
        end else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (m_state == 1) begin
                if (m_q.size() < 2) begin
                    e = {m_pc, mem[m_pc]};
                    m_q.push_back(e);
                    if (mem[m_pc] == 8'hFF) m_state = 2;
                    else m_pc = m_pc + 8'd1;
                end
            end else if (m_state == 0 && start) begin
                m_state = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 8'h00 || out_instr !== 8'h00) begin
            failures++;
            $display("FAIL reset_out got v=%b %h:%h want 0 00:00", out_valid, out_pc, out_instr);
        end
        checks++;
        if (halted !== 1'b0 || mem_pc !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got halted=%b mem_pc=%h want 0 00", halted, mem_pc);
        end
        tick();
        checks++;
        if (mem_pc !== 8'h00 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_nofetch got mem_pc=%h v=%b want 00 0", mem_pc, out_valid);
        end
    endtask

    task automatic test_halt_run();
        logic [7:0] exp_i [6];
        logic [7:0] gp[$];
        logic [7:0] gi[$];
        int         gc[$];
        exp_i = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (out_valid) begin
                gp.push_back(out_pc);
                gi.push_back(out_instr);
                gc.push_back(i);
            end
            tick();
        end
        checks++;
        if (gp.size() != 6) begin
            failures++;
            $display("FAIL halt_count got %0d want 6", gp.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (gp[k] !== 8'(k) || gi[k] !== exp_i[k] || gc[k] != gc[0] + k) begin
                    failures++;
                    $display("FAIL halt_seq[%0d] got %h:%h @%0d want %h:%h @%0d",
                             k, gp[k], gi[k], gc[k], 8'(k), exp_i[k], gc[0] + k);
                end
            end
        end
        checks++;
        if (halted !== 1'b1 || mem_pc !== 8'h05 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_state got h=%b pc=%h v=%b want 1 05 0", halted, mem_pc, out_valid);
        end
    endtask

    task automatic test_halted_redirect();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b1 || mem_pc !== 8'h05 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_in_halt got h=%b pc=%h v=%b want 1 05 0", halted, mem_pc, out_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (halted !== 1'b0 || mem_pc !== 8'h00) begin
            failures++;
            $display("FAIL halt_redir got h=%b pc=%h want 0 00", halted, mem_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 8'h11) begin
            failures++;
            $display("FAIL halt_resume got v=%b %h:%h want 1 00:11", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mem_pc !== 8'hFF) begin
            failures++;
            $display("FAIL wrap_redir got v=%b pc=%h want 0 FF", out_valid, mem_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'hFF || out_instr !== 8'hAA) begin
            failures++;
            $display("FAIL wrap_ff got v=%b %h:%h want 1 FF:AA", out_valid, out_pc, out_instr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 8'h11) begin
            failures++;
            $display("FAIL wrap_00 got v=%b %h:%h want 1 00:11", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_stall();
        logic [7:0] ei [3];
        ei = '{8'h11, 8'h22, 8'h33};
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 8'h11 || mem_pc !== 8'h02) begin
                failures++;
                $display("FAIL stall_hold got v=%b %h:%h pc=%h want 1 00:11 02",
                         out_valid, out_pc, out_instr, mem_pc);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 8'(k) || out_instr !== ei[k]) begin
                failures++;
                $display("FAIL drain[%0d] got v=%b %h:%h want 1 %h:%h",
                         k, out_valid, out_pc, out_instr, 8'(k), ei[k]);
            end
            tick();
        end
    endtask

    task automatic test_redirect_flush();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (mem_pc !== 8'h03 || out_pc !== 8'h01 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_redir got pc=%h head=%h v=%b want 03 01 1", mem_pc, out_pc, out_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc = 8'h06;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mem_pc !== 8'h06) begin
            failures++;
            $display("FAIL redir_flush got v=%b pc=%h want 0 06", out_valid, mem_pc);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_pc !== 8'h06 || out_instr !== 8'h77 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_06 got v=%b %h:%h want 1 06:77", out_valid, out_pc, out_instr);
        end
        tick();
        checks++;
        if (out_pc !== 8'h07 || out_instr !== 8'h88 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_07 got v=%b %h:%h want 1 07:88", out_valid, out_pc, out_instr);
        end
        tick();
        checks++;
        if (out_pc !== 8'h08 || out_instr !== mem[8] || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_08 got v=%b %h:%h want 1 08:%h", out_valid, out_pc, out_instr, mem[8]);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (out_valid !== 1'b1 || m_q.size() != 2) begin
            failures++;
            $display("FAIL full_before_rst got v=%b model=%0d want 1 2", out_valid, m_q.size());
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || mem_pc !== 8'h00 || halted !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got v=%b pc=%h h=%b want 0 00 0", out_valid, mem_pc, halted);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (out_valid !== 1'b0 || mem_pc !== 8'h00) begin
            failures++;
            $display("FAIL rst_idle got v=%b pc=%h want 0 00", out_valid, mem_pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            start          = ($urandom_range(0, 19) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 8'($urandom);
            out_ready      = ($urandom_range(0, 2) != 0);
            checks++;
            if (out_valid !== (m_q.size() != 0) || mem_pc !== m_pc
                || halted !== (m_state == 2)) begin
                failures++;
                $display("FAIL rand_ctl[%0d] got v=%b pc=%h h=%b want %b %h %b",
                         i, out_valid, mem_pc, halted, m_q.size() != 0, m_pc, m_state == 2);
            end
            if (m_q.size() != 0) begin
                checks++;
                if ({out_pc, out_instr} !== m_q[0]) begin
                    failures++;
                    $display("FAIL rand_head[%0d] got %h:%h want %h", i, out_pc, out_instr, m_q[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[4] = 8'h55; mem[5] = 8'hFF; mem[6] = 8'h77; mem[7] = 8'h88;
        mem[8'h40] = 8'hFF;
        mem[8'h90] = 8'hFF;
        mem[8'hFF] = 8'hAA;
        rst_n = 1'b0;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 8'h00;
        out_ready = 1'b0;
        m_state = 0;
        m_pc = 8'h00;
        #2;
        test_reset();
        test_halt_run();
        test_halted_redirect();
        test_wrap();
        test_stall();
        test_redirect_flush();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
